// File: rtl/sync_correlator.sv
`default_nettype none
// ============================================================================
// Module   : sync_correlator
// Purpose  : Correlates a 17-symbol I/Q sample window (34 sign-magnitude 2-bit
//            samples) against a programmable 17-chip I/Q sync pattern. The
//            score is produced three cycles after each window write. A
//            threshold / peak-search / hold-off FSM then emits one DETECT
//            pulse per sync-word occurrence.
// Ports    : CLK, RST_N (async, active low), EN (detector enable),
//            WE (window write strobe), RDATA_I/RDATA_Q (34-bit windows),
//            PATTERN_I/PATTERN_Q (17-chip patterns), SCORE/SCORE_VALID,
//            DETECT, PEAK_SCORE, PEAK_OFS, BUSY,
//            POLARITY (only when SYNC_INVERT_EN is defined).
// Options  : SYNC_INVERT_EN - threshold and peak search use |SCORE|, and
//            POLARITY reports the sign of the detected peak.
// Revision : 1.0 - initial release
// ============================================================================
module sync_correlator #(
  parameter int THRESH   = 60,
  parameter int PEAK_WIN = 4,
  parameter int HOLDOFF  = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        WE,
  input  logic [33:0] RDATA_I,
  input  logic [33:0] RDATA_Q,
  input  logic [16:0] PATTERN_I,
  input  logic [16:0] PATTERN_Q,
  output logic [7:0]  SCORE,
  output logic        SCORE_VALID,
  output logic        DETECT,
  output logic [7:0]  PEAK_SCORE,
  output logic [3:0]  PEAK_OFS,
  output logic        BUSY
`ifdef SYNC_INVERT_EN
  ,
  output logic        POLARITY
`endif
);

  localparam logic signed [7:0] C_THRESH   = $signed(8'(THRESH));
  localparam logic [3:0]        C_PEAK_WIN = 4'(PEAK_WIN);
  localparam logic [15:0]       C_HOLDOFF  = 16'(HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // One sample times one chip: bit1 = sign, bit0 selects magnitude 3 over 1;
  // a 0 chip flips the sign.
  function automatic logic signed [7:0] term(input logic [1:0] s, input logic p);
    logic signed [7:0] mag;
    mag = s[0] ? 8'sd3 : 8'sd1;
    return (s[1] ^ ~p) ? -mag : mag;
  endfunction

  // Sum of chips lo .. lo+n-1 of one rail; at most 9 terms, so |sum| <= 27.
  function automatic logic signed [7:0] psum(input logic [33:0] w, input logic [16:0] p,
                                             input int lo, input int n);
    logic signed [7:0] acc;
    acc = '0;
    for (int k = 0; k < 17; k++) begin
      if (k >= lo && k < lo + n) acc = acc + term(w[2*k +: 2], p[k]);
    end
    return acc;
  endfunction

  // Detection metric: signed score, or its magnitude when inverted
  // patterns must also be found.
  function automatic logic signed [7:0] metric(input logic signed [7:0] v);
`ifdef SYNC_INVERT_EN
    return v[7] ? -v : v;
`else
    return v;
`endif
  endfunction

  // ---------------------------------------------------------------- pipeline
  logic                we_q, cap_v_q, sum_v_q, score_v_q;
  logic [33:0]         win_i_q, win_q_q;
  logic [16:0]         pat_i_q, pat_q_q;
  logic signed [7:0]   sil_q, sih_q, sql_q, sqh_q;
  logic signed [7:0]   sil_d, sih_d, sql_d, sqh_d;
  logic signed [7:0]   score_q, score_d;

  always_comb begin
    sil_d   = psum(win_i_q, pat_i_q, 0, 9);
    sih_d   = psum(win_i_q, pat_i_q, 9, 8);
    sql_d   = psum(win_q_q, pat_q_q, 0, 9);
    sqh_d   = psum(win_q_q, pat_q_q, 9, 8);
    score_d = sil_q + sih_q + sql_q + sqh_q;
  end

  // The window is captured one edge after WE: the upstream shift register
  // presents the new window only after the edge that sampled WE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q      <= 1'b0;
      cap_v_q   <= 1'b0;
      sum_v_q   <= 1'b0;
      score_v_q <= 1'b0;
      win_i_q   <= '0;
      win_q_q   <= '0;
      pat_i_q   <= '0;
      pat_q_q   <= '0;
      sil_q     <= '0;
      sih_q     <= '0;
      sql_q     <= '0;
      sqh_q     <= '0;
      score_q   <= '0;
    end else begin
      we_q      <= WE;
      cap_v_q   <= we_q;
      sum_v_q   <= cap_v_q;
      score_v_q <= sum_v_q;
      if (we_q) begin
        win_i_q <= RDATA_I;
        win_q_q <= RDATA_Q;
        pat_i_q <= PATTERN_I;
        pat_q_q <= PATTERN_Q;
      end
      if (cap_v_q) begin
        sil_q <= sil_d;
        sih_q <= sih_d;
        sql_q <= sql_d;
        sqh_q <= sqh_d;
      end
      if (sum_v_q) score_q <= score_d;
    end
  end

  // --------------------------------------------------------------- detector
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d, cnt_inc;
  logic [15:0]        hcnt_q, hcnt_d, hcnt_inc;
  logic signed [7:0]  peak_q, peak_d;
  logic [3:0]         ofs_q, ofs_d;
  logic               detect_q, detect_d;
  logic [7:0]         pscore_q, pscore_d;
  logic [3:0]         pofs_q, pofs_d;
  logic signed [7:0]  w_metric, w_peak_metric;
`ifdef SYNC_INVERT_EN
  logic               pol_q, pol_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hcnt_d        = hcnt_q;
    peak_d        = peak_q;
    ofs_d         = ofs_q;
    detect_d      = 1'b0;
    pscore_d      = pscore_q;
    pofs_d        = pofs_q;
`ifdef SYNC_INVERT_EN
    pol_d         = pol_q;
`endif
    cnt_inc       = cnt_q + 4'd1;
    hcnt_inc      = hcnt_q + 16'd1;
    w_metric      = metric(score_q);
    w_peak_metric = metric(peak_q);

    if (!EN) begin
      state_d = ST_IDLE;
    end else if (score_v_q) begin
      case (state_q)
        ST_IDLE: begin
          if (w_metric >= C_THRESH) begin
            state_d = ST_TRACK;
            peak_d  = score_q;
            ofs_d   = 4'd0;
            cnt_d   = 4'd0;
          end
        end
        ST_TRACK: begin
          cnt_d = cnt_inc;
          // Strict compare: on ties the earlier peak wins.
          if (w_metric > w_peak_metric) begin
            peak_d = score_q;
            ofs_d  = cnt_inc;
          end
          // The terminating score has already been peak-compared above.
          if (w_metric < C_THRESH || cnt_inc == C_PEAK_WIN) begin
            detect_d = 1'b1;
            pscore_d = peak_d;
            pofs_d   = ofs_d;
`ifdef SYNC_INVERT_EN
            pol_d    = peak_d[7];
`endif
            state_d  = ST_HOLDOFF;
            hcnt_d   = 16'd0;
          end
        end
        ST_HOLDOFF: begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == C_HOLDOFF) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      peak_q   <= '0;
      ofs_q    <= '0;
      detect_q <= 1'b0;
      pscore_q <= '0;
      pofs_q   <= '0;
`ifdef SYNC_INVERT_EN
      pol_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      peak_q   <= peak_d;
      ofs_q    <= ofs_d;
      detect_q <= detect_d;
      pscore_q <= pscore_d;
      pofs_q   <= pofs_d;
`ifdef SYNC_INVERT_EN
      pol_q    <= pol_d;
`endif
    end
  end

  assign SCORE       = score_q;
  assign SCORE_VALID = score_v_q;
  assign DETECT      = detect_q;
  assign PEAK_SCORE  = pscore_q;
  assign PEAK_OFS    = pofs_q;
  assign BUSY        = (state_q != ST_IDLE);
`ifdef SYNC_INVERT_EN
  assign POLARITY    = pol_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_correlator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_correlator
// Purpose  : Self-checking bench for sync_correlator. Scores are predicted by
//            summing sample*chip products directly; detections and BUSY are
//            predicted by scanning the expected score stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_correlator;

  localparam int TH = 60;
  localparam int PW = 4;
  localparam int HO = 64;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        WE = 1'b0;
  logic [33:0] RDATA_I = '0;
  logic [33:0] RDATA_Q = '0;
  logic [16:0] PATTERN_I = '0;
  logic [16:0] PATTERN_Q = '0;
  logic [7:0]  SCORE;
  logic        SCORE_VALID;
  logic        DETECT;
  logic [7:0]  PEAK_SCORE;
  logic [3:0]  PEAK_OFS;
  logic        BUSY;
`ifdef SYNC_INVERT_EN
  logic        POLARITY;
`endif

  sync_correlator #(.THRESH(TH), .PEAK_WIN(PW), .HOLDOFF(HO)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .WE(WE),
    .RDATA_I(RDATA_I), .RDATA_Q(RDATA_Q),
    .PATTERN_I(PATTERN_I), .PATTERN_Q(PATTERN_Q),
    .SCORE(SCORE), .SCORE_VALID(SCORE_VALID), .DETECT(DETECT),
    .PEAK_SCORE(PEAK_SCORE), .PEAK_OFS(PEAK_OFS), .BUSY(BUSY)
`ifdef SYNC_INVERT_EN
    , .POLARITY(POLARITY)
`endif
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;

  // Expected stream (model) and observed stream (monitor).
  int exp_sc[$];
  int eb[$];
  int ed_idx[$], ed_pk[$], ed_ofs[$];
  int ob_sc[$];
  int ob_busy[$];
  int od_idx[$], od_pk[$], od_ofs[$];

  // Window presented one cycle after its WE, like a shift register output.
  logic [33:0] pend_i = '0, pend_q = '0;
  logic [16:0] ppi = '0, ppq = '0;

  // ------------------------------------------------------------- monitor
  int  nsc = 0;
  bit  prev_sv = 1'b0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      ob_sc.delete(); ob_busy.delete();
      od_idx.delete(); od_pk.delete(); od_ofs.delete();
      nsc = 0;
      prev_sv = 1'b0;
    end else begin
      if (prev_sv) ob_busy.push_back(int'(BUSY));
      if (DETECT) begin
        od_idx.push_back(nsc);
        od_pk.push_back(int'($signed(PEAK_SCORE)));
        od_ofs.push_back(int'(PEAK_OFS));
      end
      if (SCORE_VALID) begin
        ob_sc.push_back(int'($signed(SCORE)));
        nsc++;
      end
      prev_sv = SCORE_VALID;
    end
  end

  // --------------------------------------------------------------- model
  function automatic int sval(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 3;
      2'b10:   return -1;
      default: return -3;
    endcase
  endfunction

  function automatic int ref_score(input logic [33:0] wi, input logic [33:0] wq,
                                   input logic [16:0] pi, input logic [16:0] pq);
    int s = 0;
    for (int k = 0; k < 17; k++) begin
      s += sval(wi[2*k +: 2]) * (pi[k] ? 1 : -1);
      s += sval(wq[2*k +: 2]) * (pq[k] ? 1 : -1);
    end
    return s;
  endfunction

  function automatic int metric(input int v);
`ifdef SYNC_INVERT_EN
    return (v < 0) ? -v : v;
`else
    return v;
`endif
  endfunction

  // Window pair (Q in upper half) scoring exactly s against all-ones chips:
  // each step down +3 -> +1 -> -1 -> -3 costs 2.
  function automatic logic [67:0] mkwin(input int s);
    logic [67:0] w;
    int red, st;
    w = '0;
    red = (102 - s) / 2;
    for (int n = 0; n < 34; n++) begin
      st = (red > 3) ? 3 : red;
      red -= st;
      case (st)
        0:       w[2*n +: 2] = 2'b01;
        1:       w[2*n +: 2] = 2'b00;
        2:       w[2*n +: 2] = 2'b10;
        default: w[2*n +: 2] = 2'b11;
      endcase
    end
    return w;
  endfunction

  // Walk the expected scores: a crossing opens a search of up to PW further
  // scores, stopping early on a score under threshold; the first maximum is
  // the peak. HO scores after the terminating one are ignored.
  task automatic model_scan();
    int n, k;
    n = exp_sc.size();
    k = 0;
    ed_idx.delete(); ed_pk.delete(); ed_ofs.delete(); eb.delete();
    for (int i = 0; i < n; i++) eb.push_back(0);
    while (k < n) begin
      if (metric(exp_sc[k]) >= TH) begin
        int pk, e;
        pk = k;
        e = -1;
        for (int j = 1; j <= PW && k + j < n; j++) begin
          if (metric(exp_sc[k+j]) > metric(exp_sc[pk])) pk = k + j;
          if (metric(exp_sc[k+j]) < TH || j == PW) begin
            e = k + j;
            break;
          end
        end
        if (e < 0) begin
          for (int i = k; i < n; i++) eb[i] = 1;
          k = n;
        end else begin
          ed_idx.push_back(e + 1);
          ed_pk.push_back(exp_sc[pk]);
          ed_ofs.push_back(pk - k);
          for (int i = k; i < e + HO && i < n; i++) eb[i] = 1;
          k = e + HO + 1;
        end
      end else begin
        k++;
      end
    end
  endtask

  // ------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic drive(input logic we, input logic [33:0] wi, input logic [33:0] wq,
                       input logic [16:0] pi, input logic [16:0] pq);
    RDATA_I = pend_i;
    RDATA_Q = pend_q;
    PATTERN_I = ppi;
    PATTERN_Q = ppq;
    WE = we;
    if (we) begin
      pend_i = wi; pend_q = wq; ppi = pi; ppq = pq;
      exp_sc.push_back(ref_score(wi, wq, pi, pq));
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, pend_i, pend_q, ppi, ppq);
  endtask

  task automatic send_score(input int s);
    logic [67:0] w;
    w = mkwin(s);
    drive(1'b1, w[33:0], w[67:34], '1, '1);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    idle(2);
    RST_N = 1'b1;
    exp_sc.delete();
    idle(1);
  endtask

  task automatic wait_scores();
    int lim = 0;
    while (ob_sc.size() < exp_sc.size() && lim < 500) begin
      idle(1);
      lim++;
    end
    idle(3);
  endtask

  task automatic check_phase(input string tag);
    int n;
    wait_scores();
    model_scan();
    chk({tag, " nscores"}, ob_sc.size(), exp_sc.size());
    n = (ob_sc.size() < exp_sc.size()) ? ob_sc.size() : exp_sc.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s score[%0d]", tag, i), ob_sc[i], exp_sc[i]);
    chk({tag, " nbusy"}, ob_busy.size(), eb.size());
    n = (ob_busy.size() < eb.size()) ? ob_busy.size() : eb.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s busy[%0d]", tag, i), ob_busy[i], eb[i]);
    chk({tag, " ndetect"}, od_idx.size(), ed_idx.size());
    n = (od_idx.size() < ed_idx.size()) ? od_idx.size() : ed_idx.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s det_at[%0d]", tag, i), od_idx[i], ed_idx[i]);
      chk($sformatf("%s det_peak[%0d]", tag, i), od_pk[i], ed_pk[i]);
      chk($sformatf("%s det_ofs[%0d]", tag, i), od_ofs[i], ed_ofs[i]);
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [33:0] wi, wq;
    logic [16:0] pi, pq;

    // Reset state
    idle(2);
    chk("rst SCORE", SCORE, 0);
    chk("rst SCORE_VALID", SCORE_VALID, 0);
    chk("rst DETECT", DETECT, 0);
    chk("rst PEAK_SCORE", PEAK_SCORE, 0);
    chk("rst PEAK_OFS", PEAK_OFS, 0);
    chk("rst BUSY", BUSY, 0);
`ifdef SYNC_INVERT_EN
    chk("rst POLARITY", POLARITY, 0);
`endif
    RST_N = 1'b1;
    EN = 1'b1;
    idle(1);

    // Shift 4'b0101 into an all-+1 window 17 times, back-to-back
    do_reset();
    wi = '0;
    for (int i = 0; i < 17; i++) begin
      wi = {2'b01, wi[33:2]};
      drive(1'b1, wi, wi, '1, '1);
    end
    for (int i = 0; i < 70; i++) drive(1'b1, '0, '0, '1, '1);
    check_phase("shift");
    chk("shift score17", ob_sc[16], 102);

    // All 2'b00 windows: +34 forever, never busy
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, '0, '0, '1, '1);
    check_phase("flat");
    chk("flat ndetect", od_idx.size(), 0);
    chk("flat score", ob_sc[5], 34);

    // 70, 90, 80, 50 then hold-off
    do_reset();
    send_score(70); send_score(90); send_score(80); send_score(50);
    for (int i = 0; i < 70; i++) send_score(0);
    check_phase("peak");
    chk("peak PEAK_SCORE", $signed(PEAK_SCORE), 90);
    chk("peak PEAK_OFS", PEAK_OFS, 1);
    chk("peak busy_last", ob_busy[66], 1);
    chk("peak busy_free", ob_busy[67], 0);

    // Mid-TRACK asynchronous reset
    send_score(70); send_score(80);
    idle(6);
    chk("mid BUSY before", BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid SCORE", SCORE, 0);
    chk("mid SCORE_VALID", SCORE_VALID, 0);
    chk("mid DETECT", DETECT, 0);
    chk("mid PEAK_SCORE", PEAK_SCORE, 0);
    chk("mid PEAK_OFS", PEAK_OFS, 0);
    chk("mid BUSY", BUSY, 0);
    @(negedge CLK);
    do_reset();

    // Equal scores: earliest peak kept, window limit ends the search
    for (int i = 0; i < 5; i++) send_score(80);
    for (int i = 0; i < 70; i++) send_score(10);
    check_phase("tie");
    chk("tie det_at", od_idx[0], 5);
    chk("tie PEAK_OFS", PEAK_OFS, 0);

    // Crossing inside hold-off ignored, after it detected
    do_reset();
    send_score(70); send_score(40);
    send_score(80); send_score(80); send_score(40);
    for (int i = 0; i < 61; i++) send_score(0);
    send_score(70); send_score(40);
    for (int i = 0; i < 70; i++) send_score(0);
    check_phase("hold");
    chk("hold ndetect", od_idx.size(), 2);
    chk("hold det2_at", od_idx[1], 68);

    // EN dropped mid-TRACK
    do_reset();
    send_score(70); send_score(80);
    idle(6);
    chk("en BUSY track", BUSY, 1);
    EN = 1'b0;
    idle(1);
    chk("en BUSY off", BUSY, 0);
    send_score(40);
    idle(8);
    chk("en ndetect", od_idx.size(), 0);
    chk("en nscores", ob_sc.size(), 3);
    chk("en score3", ob_sc[2], 40);
    EN = 1'b1;

    // All 2'b11 windows: -102
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, '1, '1, '1, '1);
    for (int i = 0; i < 70; i++) drive(1'b1, '0, '0, '1, '1);
    check_phase("neg");
    chk("neg score", ob_sc[0], -102);
`ifdef SYNC_INVERT_EN
    chk("neg POLARITY", POLARITY, 1);
    chk("neg PEAK_SCORE", $signed(PEAK_SCORE), -102);
`endif

    // Random windows biased toward the pattern, random gaps and patterns
    do_reset();
    pi = 17'($urandom);
    pq = 17'($urandom);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        pi = 17'($urandom);
        pq = 17'($urandom);
      end
      for (int k = 0; k < 17; k++) begin
        wi[2*k+1] = ($urandom_range(0, 99) < 88) ? ~pi[k] : pi[k];
        wi[2*k]   = 1'($urandom);
        wq[2*k+1] = ($urandom_range(0, 99) < 88) ? ~pq[k] : pq[k];
        wq[2*k]   = 1'($urandom);
      end
      drive(1'b1, wi, wq, pi, pq);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    check_phase("rand");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
